// File: rtl/issue_queue_if.sv
// issue_queue_if -- fetch/decode/dispatch bundle for the instruction issue queue.
//
// Signals (named from the queue's point of view):
//   rdy_in            global enable; low freezes the queue
//   clear_in          synchronous flush (branch mispredict)
//   if_valid_in       fetch offers an instruction
//   if_instr_in       offered instruction word
//   if_pc_in          PC of the offered instruction
//   if_full_out       queue refuses pushes this cycle
//   id_valid_out      head entry valid for the decoder
//   id_instr_out      head instruction word
//   id_pc_out         head PC
//   dispatch_ready_in downstream accepts the decoded head this cycle
//   count_out         current occupancy (0..2**PTR_W)
//
// master: the fetch/dispatch side that drives the queue.
// slave:  the queue itself.
interface issue_queue_if #(
  parameter int PTR_W = 4
);
  logic             rdy_in;
  logic             clear_in;
  logic             if_valid_in;
  logic [31:0]      if_instr_in;
  logic [31:0]      if_pc_in;
  logic             if_full_out;
  logic             id_valid_out;
  logic [31:0]      id_instr_out;
  logic [31:0]      id_pc_out;
  logic             dispatch_ready_in;
  logic [PTR_W:0]   count_out;

  modport master (
    output rdy_in, clear_in, if_valid_in, if_instr_in, if_pc_in, dispatch_ready_in,
    input  if_full_out, id_valid_out, id_instr_out, id_pc_out, count_out
  );

  modport slave (
    input  rdy_in, clear_in, if_valid_in, if_instr_in, if_pc_in, dispatch_ready_in,
    output if_full_out, id_valid_out, id_instr_out, id_pc_out, count_out
  );
endinterface

// File: rtl/issue_queue.sv
// issue_queue -- circular FIFO of fetched instructions feeding the decoder.
//
// Ports:
//   clk_in  single clock, all state updates on its rising edge
//   rst_in  asynchronous active-low reset (clears pointers and occupancy)
//   bus     issue_queue_if.slave: fetch push side, decoder head side,
//           dispatch handshake, global enable, flush and occupancy
//
// The head entry is presented first-word-fall-through straight from storage;
// a pushed entry becomes visible one cycle after the push (no bypass).
module issue_queue #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic          clk_in,
  input  logic          rst_in,
  issue_queue_if.slave  bus
);

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);

  logic [31:0]      instr_mem_q [DEPTH];
  logic [31:0]      pc_mem_q    [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;

  logic full;
  logic not_empty;
  logic push;
  logic pop;

  assign full      = (count_q == FULL_CNT);
  assign not_empty = (count_q != '0);

  // A flush or a frozen queue suppresses both handshakes.
  assign push = bus.if_valid_in & ~full & bus.rdy_in & ~bus.clear_in;
  assign pop  = not_empty & bus.dispatch_ready_in & bus.rdy_in & ~bus.clear_in;

  assign bus.if_full_out  = full;
  assign bus.id_valid_out = not_empty;
  assign bus.id_instr_out = instr_mem_q[head_q];
  assign bus.id_pc_out    = pc_mem_q[head_q];
  assign bus.count_out    = count_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (bus.rdy_in) begin
      if (bus.clear_in) begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end else begin
        if (push) tail_d = (tail_q == LAST_IDX) ? '0 : tail_q + 1'b1;
        if (pop)  head_d = (head_q == LAST_IDX) ? '0 : head_q + 1'b1;
        case ({push, pop})
          2'b10:   count_d = count_q + 1'b1;
          2'b01:   count_d = count_q - 1'b1;
          default: count_d = count_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; entries are only meaningful once counted.
  always_ff @(posedge clk_in) begin
    if (push) begin
      instr_mem_q[tail_q] <= bus.if_instr_in;
      pc_mem_q[tail_q]    <= bus.if_pc_in;
    end
  end

endmodule
